// File: rtl/lcd_text_driver_if.sv
// Signal bundle between the text front end (master) and the LCD text driver (slave).
// Carries the 32-character text bus, the LCD pins and the driver status flags.
interface lcd_text_driver_if;
    logic [255:0] lcd_text;
    logic [7:0]   lcd_data;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_en;
    logic         lcd_on;
    logic         lcd_blon;
    logic         busy;
    logic         frame_done;

    modport master (
        output lcd_text,
        input  lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, frame_done
    );

    modport slave (
        input  lcd_text,
        output lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on, lcd_blon, busy, frame_done
    );
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 16x2 driver in 8-bit write-only mode: power-up wait, init commands,
// then a full two-line repaint from a snapshot whenever lcd_text differs from the shown text.
module lcd_text_driver #(
    parameter int unsigned POWERUP_CYCLES    = 1_000_000,
    parameter int unsigned EN_CYCLES         = 16,
    parameter int unsigned WAIT_CYCLES       = 2_000,
    parameter int unsigned CLEAR_WAIT_CYCLES = 100_000
) (
    input logic              clock,
    input logic              reset,
    lcd_text_driver_if.slave bus
);

    typedef enum logic [2:0] {
        S_POWERUP, S_INIT, S_IDLE, S_ADDR1, S_LINE1, S_ADDR2, S_LINE2
    } state_t;

    typedef enum logic [1:0] {B_SETUP, B_PULSE, B_HOLD} byte_state_t;

    state_t       state, state_nx;
    byte_state_t  bstate, bstate_nx;
    logic [31:0]  cnt, cnt_nx;
    logic [3:0]   idx, idx_nx;
    logic [7:0]   data, data_nx;
    logic         rs, rs_nx;
    logic [255:0] snap, snap_nx;
    logic [255:0] shown, shown_nx;
    logic         frame_done, frame_done_nx;

    logic         writing;
    logic [31:0]  hold_len;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    // Byte k of the text sits at bits [8*(31-k) +: 8]; NUL padding is shown as a space.
    function automatic logic [7:0] char_at(input logic [255:0] t, input logic [4:0] k);
        logic [7:0] c;
        c = t[{~k, 3'b000} +: 8];
        return (c == 8'h00) ? 8'h20 : c;
    endfunction

    assign writing  = (state == S_INIT)  || (state == S_ADDR1) || (state == S_LINE1) ||
                      (state == S_ADDR2) || (state == S_LINE2);
    assign hold_len = (!rs && data == 8'h01) ? CLEAR_WAIT_CYCLES : WAIT_CYCLES;

    // NOTE: every next-state variable gets its default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_nx      = state;
        bstate_nx     = bstate;
        cnt_nx        = cnt;
        idx_nx        = idx;
        data_nx       = data;
        rs_nx         = rs;
        snap_nx       = snap;
        shown_nx      = shown;
        frame_done_nx = 1'b0;

        case (state)
            S_POWERUP: begin
                if (cnt == POWERUP_CYCLES - 32'd1) begin
                    state_nx  = S_INIT;
                    bstate_nx = B_SETUP;
                    cnt_nx    = '0;
                    idx_nx    = '0;
                    data_nx   = init_cmd(2'd0);
                    rs_nx     = 1'b0;
                end else begin
                    cnt_nx = cnt + 32'd1;
                end
            end

            S_IDLE: begin
                if (bus.lcd_text != shown) begin
                    snap_nx   = bus.lcd_text;
                    state_nx  = S_ADDR1;
                    bstate_nx = B_SETUP;
                    cnt_nx    = '0;
                    data_nx   = 8'h80;
                    rs_nx     = 1'b0;
                end
            end

            default: begin
                case (bstate)
                    B_SETUP: begin
                        bstate_nx = B_PULSE;
                        cnt_nx    = '0;
                    end
                    B_PULSE: begin
                        if (cnt == EN_CYCLES - 32'd1) begin
                            bstate_nx = B_HOLD;
                            cnt_nx    = '0;
                        end else begin
                            cnt_nx = cnt + 32'd1;
                        end
                    end
                    B_HOLD: begin
                        if (cnt == hold_len - 32'd1) begin
                            // Byte finished: choose the next byte and present it in SETUP.
                            bstate_nx = B_SETUP;
                            cnt_nx    = '0;
                            case (state)
                                S_INIT: begin
                                    if (idx == 4'd3) begin
                                        snap_nx  = bus.lcd_text;
                                        state_nx = S_ADDR1;
                                        data_nx  = 8'h80;
                                        rs_nx    = 1'b0;
                                    end else begin
                                        idx_nx  = idx + 4'd1;
                                        data_nx = init_cmd(idx[1:0] + 2'd1);
                                    end
                                end
                                S_ADDR1: begin
                                    state_nx = S_LINE1;
                                    idx_nx   = '0;
                                    data_nx  = char_at(snap, 5'd0);
                                    rs_nx    = 1'b1;
                                end
                                S_LINE1: begin
                                    if (idx == 4'd15) begin
                                        state_nx = S_ADDR2;
                                        data_nx  = 8'hC0;
                                        rs_nx    = 1'b0;
                                    end else begin
                                        idx_nx  = idx + 4'd1;
                                        data_nx = char_at(snap, {1'b0, idx + 4'd1});
                                    end
                                end
                                S_ADDR2: begin
                                    state_nx = S_LINE2;
                                    idx_nx   = '0;
                                    data_nx  = char_at(snap, 5'd16);
                                    rs_nx    = 1'b1;
                                end
                                default: begin
                                    if (idx == 4'd15) begin
                                        state_nx      = S_IDLE;
                                        shown_nx      = snap;
                                        frame_done_nx = 1'b1;
                                    end else begin
                                        idx_nx  = idx + 4'd1;
                                        data_nx = char_at(snap, {1'b1, idx + 4'd1});
                                    end
                                end
                            endcase
                        end else begin
                            cnt_nx = cnt + 32'd1;
                        end
                    end
                    default: bstate_nx = B_SETUP;
                endcase
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
    // NOTE: snap and shown are ordinary wide registers, not memories, so they take the async reset like the rest.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_POWERUP;
            bstate     <= B_SETUP;
            cnt        <= '0;
            idx        <= '0;
            data       <= 8'h00;
            rs         <= 1'b0;
            snap       <= '0;
            shown      <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            bstate     <= bstate_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            data       <= data_nx;
            rs         <= rs_nx;
            snap       <= snap_nx;
            shown      <= shown_nx;
            frame_done <= frame_done_nx;
        end
    end

    // Strobe decoded from registered state, so reset drops it without a clock edge.
    assign bus.lcd_en     = writing && (bstate == B_PULSE);
    assign bus.lcd_data   = data;
    assign bus.lcd_rs     = rs;
    assign bus.lcd_rw     = 1'b0;
    assign bus.lcd_on     = 1'b1;
    assign bus.lcd_blon   = 1'b1;
    assign bus.busy       = (state != S_IDLE);
    assign bus.frame_done = frame_done;

endmodule

// File: tb/tb_lcd_text_driver.sv
// Scoreboard bench for lcd_text_driver: stimulus pushes the expected LCD byte stream,
// a negedge monitor pops and compares every strobed byte and frame_done pulse.
module tb_lcd_text_driver;

    localparam int unsigned POWERUP = 20;
    localparam int unsigned EN      = 2;
    localparam int unsigned WAITC   = 4;
    localparam int unsigned CLR     = 10;

    typedef struct packed {
        logic       fd;
        logic       rs;
        logic [7:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    lcd_text_driver_if dut_if ();

    lcd_text_driver #(
        .POWERUP_CYCLES   (POWERUP),
        .EN_CYCLES        (EN),
        .WAIT_CYCLES      (WAITC),
        .CLEAR_WAIT_CYCLES(CLR)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (dut_if)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic [255:0] model_shown;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    function automatic logic [255:0] str2txt(input string s);
        logic [255:0] t;
        int n;
        t = '0;
        n = s.len();
        for (int i = 0; i < n; i++) t[8*(n-1-i) +: 8] = s[i];
        return t;
    endfunction

    function automatic logic [255:0] rand_text();
        logic [255:0] t;
        for (int i = 0; i < 32; i++)
            t[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
        return t;
    endfunction

    // Reference: character k (0 = line 1 col 0) is the k-th byte from the left, NUL shown as space.
    task automatic push_frame(input logic [255:0] t);
        logic [7:0] c;
        exp_q.push_back('{fd: 1'b0, rs: 1'b0, data: 8'h80});
        for (int k = 0; k < 32; k++) begin
            if (k == 16) exp_q.push_back('{fd: 1'b0, rs: 1'b0, data: 8'hC0});
            c = t[255 - 8*k -: 8];
            exp_q.push_back('{fd: 1'b0, rs: 1'b1, data: (c == 8'h00) ? 8'h20 : c});
        end
        exp_q.push_back('{fd: 1'b1, rs: 1'b0, data: 8'h00});
    endtask

    task automatic push_init_and_frame(input logic [255:0] t);
        exp_q.push_back('{fd: 1'b0, rs: 1'b0, data: 8'h38});
        exp_q.push_back('{fd: 1'b0, rs: 1'b0, data: 8'h0C});
        exp_q.push_back('{fd: 1'b0, rs: 1'b0, data: 8'h01});
        exp_q.push_back('{fd: 1'b0, rs: 1'b0, data: 8'h06});
        push_frame(t);
        model_shown = t;
    endtask

    // Monitor state
    int         en_rises = 0;
    int         since_rst = 0;
    int         prev_rise = 0;
    int         hi_cnt = 0;
    int         win_cnt = 0;
    int         win_len = 0;
    logic       en_prev = 1'b0;
    logic       first_rise = 1'b1;
    logic       fd_between = 1'b0;
    logic       prev_clear = 1'b0;
    logic       win_on = 1'b0;
    logic       stable = 1'b1;
    logic [7:0] cap_data = 8'h00;
    logic       cap_rs = 1'b0;

    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            en_prev    = 1'b0;
            hi_cnt     = 0;
            win_on     = 1'b0;
            first_rise = 1'b1;
            fd_between = 1'b0;
            since_rst  = 0;
        end else begin
            since_rst++;
            if (win_on) begin
                if (dut_if.lcd_data !== cap_data || dut_if.lcd_rs !== cap_rs) stable = 1'b0;
                win_cnt++;
                if (win_cnt == win_len || (dut_if.lcd_en && !en_prev)) begin
                    check("data_rs_stable", 32'(stable), 32'd1);
                    win_on = 1'b0;
                end
            end

            if (dut_if.lcd_en && !en_prev) begin
                en_rises++;
                if (first_rise)
                    check("powerup_gap", since_rst, POWERUP + 1);
                else if (!fd_between)
                    check("rise_spacing", since_rst - prev_rise,
                          prev_clear ? (1 + EN + CLR) : (1 + EN + WAITC));
                first_rise = 1'b0;
                fd_between = 1'b0;
                prev_rise  = since_rst;
                prev_clear = !dut_if.lcd_rs && dut_if.lcd_data == 8'h01;
                cap_data   = dut_if.lcd_data;
                cap_rs     = dut_if.lcd_rs;
                stable     = 1'b1;
                win_cnt    = 1;
                win_len    = EN + (prev_clear ? CLR : WAITC);
                win_on     = 1'b1;
                hi_cnt     = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got rs=%0d data=0x%02h, nothing expected at %0t",
                             dut_if.lcd_rs, dut_if.lcd_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("lcd_byte", {22'd0, 1'b0, dut_if.lcd_rs, dut_if.lcd_data}, {22'd0, e});
                end
            end else if (dut_if.lcd_en) begin
                hi_cnt++;
            end else if (en_prev) begin
                check("en_width", hi_cnt, EN);
            end

            if (dut_if.frame_done) begin
                fd_between = 1'b1;
                check("busy_at_done", 32'(dut_if.busy), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got pulse, nothing expected at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_done_order", 32'd1, 32'(e.fd));
                end
            end
            en_prev = dut_if.lcd_en;
        end
    end

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (!dut_if.busy && exp_q.size() == 0) return;
        end
        timeout_fail("wait_idle");
    endtask

    task automatic wait_rises(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock); #1;
            if (en_rises >= target) return;
        end
        timeout_fail("wait_rises");
    endtask

    task automatic release_reset();
        @(negedge clock); #1;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] t, t2;
        int n;
        logic painted, seen;

        dut_if.lcd_text = '0;
        model_shown     = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_lcd_en",      32'(dut_if.lcd_en),     32'd0);
        check("rst_lcd_data",    32'(dut_if.lcd_data),   32'd0);
        check("rst_lcd_rs",      32'(dut_if.lcd_rs),     32'd0);
        check("rst_lcd_rw",      32'(dut_if.lcd_rw),     32'd0);
        check("rst_lcd_on",      32'(dut_if.lcd_on),     32'd1);
        check("rst_lcd_blon",    32'(dut_if.lcd_blon),   32'd1);
        check("rst_busy",        32'(dut_if.busy),       32'd1);
        check("rst_frame_done",  32'(dut_if.frame_done), 32'd0);

        // Init sequence plus forced blank frame
        push_init_and_frame('0);
        release_reset();
        wait_idle(2000);

        // String mapping with left zero padding
        t = str2txt("Enter c_real.");
        dut_if.lcd_text = t;
        push_frame(t);
        model_shown = t;
        wait_idle(2000);

        // No repaint while text is unchanged
        n = en_rises;
        repeat (1000) @(posedge clock);
        #1;
        check("no_repaint_rises", en_rises - n, 0);
        check("no_repaint_busy",  32'(dut_if.busy), 32'd0);

        // Change during LINE1: frame completes, next one starts right after
        t = str2txt("Display c_real");
        dut_if.lcd_text = t;
        push_frame(t);
        wait_rises(en_rises + 4, 500);
        t2 = str2txt("Enter z_real.");
        dut_if.lcd_text = t2;
        push_frame(t2);
        model_shown = t2;
        seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clock); #1;
            if (dut_if.frame_done) seen = 1'b1;
        end
        if (!seen) timeout_fail("first_frame_done");
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock); #1;
            n++;
            if (dut_if.lcd_en) seen = 1'b1;
        end
        check("restart_latency", n, 2);
        wait_idle(2000);

        // Randomized texts, sometimes changed mid-frame
        for (int it = 0; it < 10; it++) begin
            t = rand_text();
            dut_if.lcd_text = t;
            painted = 1'b0;
            if (t != model_shown) begin
                push_frame(t);
                model_shown = t;
                painted = 1'b1;
            end
            if (painted && $urandom_range(0, 1) == 1) begin
                wait_rises(en_rises + int'($urandom_range(1, 30)), 2000);
                t2 = ($urandom_range(0, 3) == 0) ? t : rand_text();
                dut_if.lcd_text = t2;
                if (t2 != model_shown) begin
                    push_frame(t2);
                    model_shown = t2;
                end
            end
            wait_idle(3000);
        end

        // Reset while lcd_en is high: strobe drops immediately, init replays
        t = rand_text();
        dut_if.lcd_text = t;
        push_frame(t);
        wait_rises(en_rises + 5, 500);
        check("en_high_before_reset", 32'(dut_if.lcd_en), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("async_en_drop", 32'(dut_if.lcd_en), 32'd0);
        check("reset_busy",    32'(dut_if.busy),   32'd1);
        exp_q.delete();
        repeat (3) @(posedge clock);
        t2 = rand_text();
        dut_if.lcd_text = t2;
        push_init_and_frame(t2);
        release_reset();
        wait_idle(2000);
        check("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_text_driver.md
# lcd_text_driver

Consumes the 32-character `lcd_text` bus produced by the parameter-entry front end and drives the board's HD44780-compatible 16x2 character LCD in 8-bit write-only mode. Runs the controller power-up/init sequence once after reset. After that it repaints both lines whenever `lcd_text` differs from what is currently displayed. It is the display end of the `lcd_text` interface and sits between the entry FSM and the LCD pins.

## Interface
- `POWERUP_CYCLES`, default 1_000_000: idle cycles after reset before the first command (20 ms at 50 MHz).
- `EN_CYCLES`, default 16: cycles `lcd_en` is held high per byte.
- `WAIT_CYCLES`, default 2_000: post-pulse wait for normal commands and characters (40 us).
- `CLEAR_WAIT_CYCLES`, default 100_000: post-pulse wait after the clear command 0x01 (2 ms).
- `clock` input, 1 bit: single clock.
- `reset` input, 1 bit: asynchronous, active-high.
- `lcd_text` input, 256 bits: 32 chars. Bits [255:248] are line 1 column 0, and chars run left to right, MSB first. Bits [127:120] are line 2 column 0.
- `lcd_data` output, 8 bits: LCD data bus.
- `lcd_rs` output, 1 bit: 0 = command, 1 = character.
- `lcd_rw` output, 1 bit: tied 0 (write only).
- `lcd_en` output, 1 bit: LCD enable strobe.
- `lcd_on`, `lcd_blon` outputs, 1 bit each: constant 1.
- `busy` output, 1 bit: high during power-up, init, and any frame.
- `frame_done` output, 1 bit: one-cycle pulse after the last character of a frame completes.

## Operation
- Top FSM states: POWERUP → INIT → IDLE → ADDR1 → LINE1 → ADDR2 → LINE2 → IDLE.
- POWERUP: count `POWERUP_CYCLES`, with `lcd_en`=0.
- INIT: write commands 0x38, 0x0C, 0x01, 0x06 in order, all with rs=0. Then force one frame regardless of content.
- IDLE: `busy`=0. Starts a frame when `lcd_text` != `shown`, a 256-bit register holding the last painted text.
- Frame start: latch `lcd_text` into `snap` in the same cycle as the frame starts. The frame paints only from `snap`. `shown` <= `snap` at `frame_done`.
- ADDR1: write command 0x80.
- LINE1: write chars from `snap` bytes 0..15, with rs=1.
- ADDR2: write command 0xC0.
- LINE2: write chars from bytes 16..31.
- Character mapping: byte 0x00 is sent as 0x20 (space). This matters because Verilog strings shorter than 32 chars are zero-padded on the left. All other bytes pass through unchanged.
- Byte-write sub-FSM, SETUP → PULSE → HOLD:
  - SETUP: 1 cycle, `lcd_data`/`lcd_rs` valid, `lcd_en`=0.
  - PULSE: `EN_CYCLES` cycles with `lcd_en`=1.
  - HOLD: `lcd_en`=0, data held for `WAIT_CYCLES` cycles, or `CLEAR_WAIT_CYCLES` after 0x01.
- A byte costs 1+`EN_CYCLES`+wait cycles. A frame is 34 bytes.
- `lcd_data` and `lcd_rs` change only in SETUP, and stay stable through PULSE and HOLD.

## Timing
- Reset values:
  - State POWERUP, all counters 0.
  - `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0.
  - `lcd_on`=1, `lcd_blon`=1.
  - `busy`=1, `frame_done`=0.
  - `snap`=0, `shown`=0.
- Reset mid-operation: `lcd_en` drops to 0 asynchronously. Any partial byte is abandoned. After release, the full POWERUP+INIT sequence replays.
- If `lcd_text` changes during a frame, the frame completes unchanged. The mismatch with `shown` is then seen in IDLE and starts the next frame 1 cycle after `frame_done`.
- Minimum IDLE residency between frames is 1 cycle. `busy` is low for that cycle.
- `frame_done` is asserted in the cycle after the final HOLD ends, coincident with entering IDLE.
- No input handshake: `lcd_text` is level-sampled. Glitch-free from the producer is not required, because only the snapshot is displayed.

## Test plan
Benches use `POWERUP_CYCLES`=20, `EN_CYCLES`=2, `WAIT_CYCLES`=4, `CLEAR_WAIT_CYCLES`=10. A normal byte is 7 cycles and the clear is 13.
- Init sequence:
  - Stimulus: release reset with `lcd_text`=0.
  - Response: no `lcd_en` for the first 20 cycles. Then en-strobed command bytes 0x38, 0x0C, 0x01, 0x06 with rs=0, and a 10-cycle gap after 0x01.
  - Next comes a forced frame: 0x80, 16×0x20, 0xC0, 16×0x20, then one `frame_done` pulse with `busy`=0.
- String mapping:
  - Stimulus: `lcd_text`="Enter c_real." after init.
  - Response: line 1 shows 16×0x20. Line 2 bytes are 0x20,0x20,0x20 then 'E','n','t','e','r',' ','c','_','r','e','a','l','.'.
- No repaint on unchanged text:
  - Stimulus: hold `lcd_text` constant for 1000 cycles after `frame_done`.
  - Response: zero `lcd_en` pulses, `busy`=0.
- Change mid-frame:
  - Stimulus: switch from "Display c_real" to "Enter z_real." during LINE1.
  - Response: the current frame completes with all "Display c_real" bytes. A second frame starts 1 cycle after `frame_done` and carries "Enter z_real.".
- Reset with `lcd_en` high:
  - Stimulus: assert `reset` during PULSE.
  - Response: `lcd_en`=0 in the same cycle without waiting for a clock edge. `busy`=1. After release, the full init sequence replays.
- Strobe timing:
  - Check: every `lcd_en` high pulse is exactly 2 cycles.
  - Check: `lcd_data`/`lcd_rs` are stable from SETUP through HOLD.
  - Check: the spacing between rising edges is 7 cycles, or 13 after 0x01.
